// File: rtl/bus_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_access_arbiter_if
//
// Purpose : APB-like single-port bus between the core-side arbiter and the
//           memory/peripheral side.
//
// Signals :
//   addr   [31:0]  bus address, stable from SETUP through ACCESS
//   select         bus select, high in SETUP and ACCESS
//   enable         bus enable, high in ACCESS only
//   write          1 = write transfer
//   wdata  [31:0]  write data, stable from SETUP through ACCESS
//   rdata  [31:0]  read data from the slave, sampled when ready is high
//   ready          slave completes the ACCESS phase in the cycle it is high
//
// Modports:
//   master : the arbiter (drives addr/select/enable/write/wdata)
//   slave  : the responding device (drives rdata/ready)
// ---------------------------------------------------------------------------
interface bus_access_arbiter_if;

   logic [31:0] addr;
   logic        select;
   logic        enable;
   logic        write;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport master (
      output addr,
      output select,
      output enable,
      output write,
      output wdata,
      input  rdata,
      input  ready
   );

   modport slave (
      input  addr,
      input  select,
      input  enable,
      input  write,
      input  wdata,
      output rdata,
      output ready
   );

endinterface

// File: rtl/bus_access_arbiter.sv
// ---------------------------------------------------------------------------
// bus_access_arbiter
//
// Purpose : Shares the core's single APB-like bus port between the
//           instruction-fetch path and the load/store path, sequences the
//           two-phase SETUP/ACCESS protocol, captures read data and returns
//           a one-cycle completion pulse to the owning requester.
//           Load/store wins contested arbitration unless it has already won
//           MaxLsuStreak contested grants in a row, in which case a pending
//           fetch wins.  An ACCESS phase that sees ready low for
//           TimeoutCycles cycles is completed with respError=1 (0 disables).
//
// Ports   :
//   clk, rst            clock, asynchronous active-low reset
//   fetchReq/fetchAddr  fetch request (read only) and its address
//   fetchDone           one-cycle completion pulse to fetch
//   lsuReq/lsuAddr/lsuWrite/lsuWdata
//                       load/store request and its transfer attributes
//   lsuDone             one-cycle completion pulse to load/store
//   respRdata           captured read data, valid while a done pulse is high
//   respError           timeout flag, valid with a done pulse
//   owner               current/last grant: 0 = fetch, 1 = lsu
//   busy                high in SETUP, ACCESS and RESP
//   state_dbg           current FSM state (IDLE/SETUP/ACCESS/RESP = 0..3)
//   bus                 APB-like master port (see bus_access_arbiter_if)
//
// Requester handshake:
//   A requester raises req with its address/attributes and holds all of
//   them stable until its done pulse.  Done is high for exactly one cycle.
//   In the done cycle the requester either drops req or replaces the
//   attributes with its next transaction; a req still high in the IDLE
//   cycle after done is arbitrated as a new transfer.  The losing requester
//   simply keeps req high and is re-arbitrated in the next IDLE cycle.
// ---------------------------------------------------------------------------
module bus_access_arbiter #(
   parameter int MaxLsuStreak  = 4,
   parameter int TimeoutCycles = 255
) (
   input  logic                 clk,
   input  logic                 rst,

   input  logic                 fetchReq,
   input  logic [31:0]          fetchAddr,
   output logic                 fetchDone,

   input  logic                 lsuReq,
   input  logic [31:0]          lsuAddr,
   input  logic                 lsuWrite,
   input  logic [31:0]          lsuWdata,
   output logic                 lsuDone,

   output logic [31:0]          respRdata,
   output logic                 respError,
   output logic                 owner,
   output logic                 busy,
   output logic [1:0]           state_dbg,

   bus_access_arbiter_if.master bus
);

   // ------------------------------------------------------------------------
   // FSM encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   // Counter widths: streak must be able to hold MaxLsuStreak itself; the
   // timeout counter must be able to hold TimeoutCycles (at least 1 bit).
   localparam int StreakW = (MaxLsuStreak > 1) ? $clog2(MaxLsuStreak + 1) : 1;
   localparam int TmoW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

   localparam logic [StreakW-1:0] StreakMax = StreakW'(MaxLsuStreak);
   // Value the counter holds on the last tolerated ready-low cycle.
   localparam logic [TmoW-1:0]    TmoLast   =
      TmoW'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);

   logic [1:0]          state;
   logic [31:0]         addr_q;
   logic                write_q;
   logic [31:0]         wdata_q;
   logic [StreakW-1:0]  streak;
   logic [TmoW-1:0]     tmo_cnt;

   logic                grant_lsu;
   logic                grant_fetch;
   logic                timeout_hit;

   // ------------------------------------------------------------------------
   // Arbitration (only meaningful in IDLE).  LSU has fixed priority; once it
   // has won MaxLsuStreak contested grants back to back, a waiting fetch is
   // let through.
   // ------------------------------------------------------------------------
   always_comb begin
      grant_lsu   = 1'b0;
      grant_fetch = 1'b0;
      if (state == ST_IDLE) begin
         if (lsuReq && !(fetchReq && (streak == StreakMax))) begin
            grant_lsu = 1'b1;
         end else if (fetchReq) begin
            grant_fetch = 1'b1;
         end
      end
   end

   // Timeout fires on the TimeoutCycles-th ready-low ACCESS cycle.
   assign timeout_hit = (TimeoutCycles != 0) && (tmo_cnt == TmoLast);

   // ------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         owner     <= 1'b0;
         streak    <= '0;
         tmo_cnt   <= '0;
         respRdata <= '0;
         respError <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_lsu || grant_fetch) begin
                  state <= ST_SETUP;
                  owner <= grant_lsu;
                  if (grant_lsu) begin
                     addr_q  <= lsuAddr;
                     write_q <= lsuWrite;
                     wdata_q <= lsuWdata;
                  end else begin
                     // Fetch is always a read; park write data at zero.
                     addr_q  <= fetchAddr;
                     write_q <= 1'b0;
                     wdata_q <= '0;
                  end
                  // Streak only grows on contested LSU wins; any fetch grant
                  // or uncontested LSU grant restarts it.
                  if (grant_lsu && fetchReq) begin
                     if (streak != StreakMax) begin
                        streak <= streak + 1'b1;
                     end
                  end else begin
                     streak <= '0;
                  end
               end
            end

            ST_SETUP: begin
               state   <= ST_ACCESS;
               tmo_cnt <= '0;
            end

            ST_ACCESS: begin
               if (bus.ready) begin
                  state     <= ST_RESP;
                  respRdata <= write_q ? 32'd0 : bus.rdata;
                  respError <= 1'b0;
               end else begin
                  if (tmo_cnt != {TmoW{1'b1}}) begin
                     tmo_cnt <= tmo_cnt + 1'b1;
                  end
                  if (timeout_hit) begin
                     state     <= ST_RESP;
                     respRdata <= '0;
                     respError <= 1'b1;
                  end
               end
            end

            ST_RESP: begin
               // Requests are not looked at here; the next grant happens in
               // the following IDLE cycle.
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs.  select/enable/done decode straight from the state register so
   // that an asynchronous reset drops them in the same instant.
   // ------------------------------------------------------------------------
   assign bus.addr   = addr_q;
   assign bus.write  = write_q;
   assign bus.wdata  = wdata_q;
   assign bus.select = (state == ST_SETUP) || (state == ST_ACCESS);
   assign bus.enable = (state == ST_ACCESS);

   assign fetchDone  = (state == ST_RESP) && !owner;
   assign lsuDone    = (state == ST_RESP) &&  owner;
   assign busy       = (state != ST_IDLE);
   assign state_dbg  = state;

endmodule

// File: tb/tb_bus_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_access_arbiter
//
// Drives both requesters and the bus slave side, and predicts every cycle's
// outputs from a transaction-timeline model: a grant decided in IDLE cycle c
// puts SETUP at c+1, ACCESS from c+2, and done at c+3+waits (or c+2+Tmo on
// timeout).  The bench also decides the slave's wait states, so ready/rdata
// are driven from the model's own schedule.
// ---------------------------------------------------------------------------
module tb_bus_access_arbiter;

   localparam int MaxStreak = 4;
   localparam int Tmo       = 8;

   // ------------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // DUT
   // ------------------------------------------------------------------------
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_done;
   logic        l_req;
   logic [31:0] l_addr;
   logic        l_write;
   logic [31:0] l_wdata;
   logic        l_done;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        owner;
   logic        busy;
   logic [1:0]  state_dbg;

   bus_access_arbiter_if bus_if ();

   bus_access_arbiter #(
      .MaxLsuStreak (MaxStreak),
      .TimeoutCycles(Tmo)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fetchReq  (f_req),
      .fetchAddr (f_addr),
      .fetchDone (f_done),
      .lsuReq    (l_req),
      .lsuAddr   (l_addr),
      .lsuWrite  (l_write),
      .lsuWdata  (l_wdata),
      .lsuDone   (l_done),
      .respRdata (resp_rdata),
      .respError (resp_error),
      .owner     (owner),
      .busy      (busy),
      .state_dbg (state_dbg),
      .bus       (bus_if)
   );

   // ------------------------------------------------------------------------
   // Scoreboard state
   // ------------------------------------------------------------------------
   int n_compared   = 0;
   int n_mismatched = 0;
   int cyc          = 0;

   logic [0:0] exp_q[$];      // expected grant order (1 = lsu)
   bit         record_grants = 1'b0;

   // transaction-timeline model
   bit          t_active   = 1'b0;
   int          t_setup    = 0;
   int          t_done     = 0;
   bit          t_owner    = 1'b0;
   bit          t_err      = 1'b0;
   logic [31:0] t_raw      = '0;
   logic [31:0] t_rresp    = '0;
   int          idle_from  = 0;
   int          streak     = 0;
   logic [31:0] exp_addr   = '0;
   logic [31:0] exp_wdata  = '0;
   logic        exp_write  = 1'b0;
   logic        exp_owner  = 1'b0;

   // stimulus knobs
   int          raise_pct        = 0;
   int          repeat_pct       = 0;
   int          wait_mode        = 0;    // <0: random per transaction
   int          lsu_repeat_left  = 0;
   bit          force_rdata      = 1'b0;
   logic [31:0] forced_rdata     = '0;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic int pick_wait();
      if ($urandom_range(0, 9) == 0) return int'($urandom_range(6, 12));
      return int'($urandom_range(0, 3));
   endfunction

   // Decide the grant for IDLE cycle c from the current request levels.
   task automatic arbitrate(input int c);
      bit win_lsu;
      int w;
      if (!(f_req || l_req)) return;
      win_lsu = l_req && !(f_req && (streak == MaxStreak));
      if (win_lsu && f_req) streak = (streak < MaxStreak) ? streak + 1 : MaxStreak;
      else                  streak = 0;
      w         = (wait_mode >= 0) ? wait_mode : pick_wait();
      t_active  = 1'b1;
      t_setup   = c + 1;
      t_owner   = win_lsu;
      t_err     = (w >= Tmo);
      t_done    = t_err ? (c + 2 + Tmo) : (c + 3 + w);
      t_raw     = force_rdata ? forced_rdata : $urandom;
      exp_owner = win_lsu;
      exp_addr  = win_lsu ? l_addr : f_addr;
      exp_write = win_lsu ? l_write : 1'b0;
      exp_wdata = win_lsu ? l_wdata : 32'd0;
      t_rresp   = (exp_write || t_err) ? 32'd0 : t_raw;
   endtask

   task automatic check_cycle();
      bit in_setup, in_access, in_resp;
      logic [0:0] g;
      in_setup  = t_active && (cyc == t_setup);
      in_access = t_active && (cyc > t_setup) && (cyc < t_done);
      in_resp   = t_active && (cyc == t_done);
      check_val("select", 32'(bus_if.select), 32'(in_setup || in_access));
      check_val("enable", 32'(bus_if.enable), 32'(in_access));
      check_val("busy",   32'(busy),          32'(t_active));
      check_val("fetch_done", 32'(f_done), 32'(in_resp && !t_owner));
      check_val("lsu_done",   32'(l_done), 32'(in_resp &&  t_owner));
      check_val("addr",   bus_if.addr,        exp_addr);
      check_val("write",  32'(bus_if.write),  32'(exp_write));
      check_val("wdata",  bus_if.wdata,       exp_wdata);
      check_val("owner",  32'(owner),         32'(exp_owner));
      if (in_resp) begin
         check_val("resp_rdata", resp_rdata,       t_rresp);
         check_val("resp_error", 32'(resp_error),  32'(t_err));
      end
      if (record_grants && bus_if.select && !bus_if.enable && exp_q.size() > 0) begin
         g = exp_q.pop_front();
         check_val("grant_order", 32'(owner), 32'(g));
      end
   endtask

   // One clock cycle; entered and left at a falling edge.
   task automatic step();
      check_cycle();
      if (t_active && cyc == t_done) begin
         t_active  = 1'b0;
         idle_from = cyc + 1;
         if (t_owner) begin
            if (lsu_repeat_left > 0 || int'($urandom_range(1, 100)) <= repeat_pct) begin
               if (lsu_repeat_left > 0) lsu_repeat_left--;
               l_addr = l_addr + 32'd4;
            end else begin
               l_req = 1'b0;
            end
         end else begin
            if (int'($urandom_range(1, 100)) <= repeat_pct) f_addr = f_addr + 32'd4;
            else f_req = 1'b0;
         end
      end
      if (!f_req && int'($urandom_range(1, 100)) <= raise_pct) begin
         f_req  = 1'b1;
         f_addr = $urandom;
      end
      if (!l_req && int'($urandom_range(1, 100)) <= raise_pct) begin
         l_req   = 1'b1;
         l_addr  = $urandom;
         l_write = 1'($urandom_range(0, 1));
         l_wdata = $urandom;
      end
      if (!t_active && cyc >= idle_from) arbitrate(cyc);
      if (t_active && cyc > t_setup && cyc < t_done) begin
         if (!t_err && cyc == t_done - 1) begin
            bus_if.ready = 1'b1;
            bus_if.rdata = t_raw;
         end else begin
            bus_if.ready = 1'b0;
            bus_if.rdata = $urandom;
         end
      end else begin
         bus_if.ready = 1'($urandom_range(0, 1));
         bus_if.rdata = $urandom;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      f_req = 1'b0; f_addr = '0;
      l_req = 1'b0; l_addr = '0; l_write = 1'b0; l_wdata = '0;
      bus_if.ready = 1'b0; bus_if.rdata = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_select",  32'(bus_if.select), 32'd0);
      check_val("rst_enable",  32'(bus_if.enable), 32'd0);
      check_val("rst_busy",    32'(busy),          32'd0);
      check_val("rst_addr",    bus_if.addr,        32'd0);
      check_val("rst_wdata",   bus_if.wdata,       32'd0);
      check_val("rst_rdata",   resp_rdata,         32'd0);
      check_val("rst_error",   32'(resp_error),    32'd0);
      check_val("rst_owner",   32'(owner),         32'd0);
      check_val("rst_fdone",   32'(f_done),        32'd0);
      check_val("rst_ldone",   32'(l_done),        32'd0);
      rst = 1'b1;
      @(negedge clk);
      run(2);

      // single fetch, immediate ready
      f_addr = 32'h8000_0000; f_req = 1'b1;
      wait_mode = 0; force_rdata = 1'b1; forced_rdata = 32'h0000_0013;
      run(6);
      force_rdata = 1'b0;

      // LSU write with three wait states
      l_addr = 32'h4000_0000; l_write = 1'b1; l_wdata = 32'hDEAD_BEEF; l_req = 1'b1;
      wait_mode = 3;
      run(9);

      // back-to-back LSU: next transaction presented in the done cycle
      l_addr = 32'h4000_0000; l_write = 1'b0; l_req = 1'b1;
      wait_mode = 0; lsu_repeat_left = 1;
      run(10);

      // starvation limiter with both requests held continuously
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(1'b1); exp_q.push_back(1'b1);
         exp_q.push_back(1'b1); exp_q.push_back(1'b1);
         exp_q.push_back(1'b0);
      end
      f_addr = 32'h8000_1000; f_req = 1'b1;
      l_addr = 32'h4000_1000; l_write = 1'b0; l_req = 1'b1;
      repeat_pct = 100; record_grants = 1'b1;
      run(48);
      record_grants = 1'b0;
      check_val("grant_cnt", 32'(exp_q.size()), 32'd0);
      repeat_pct = 0;
      run(16);

      // timeout, then a normal transfer
      l_addr = 32'h4000_2000; l_write = 1'b0; l_req = 1'b1;
      wait_mode = 20;
      run(14);
      f_addr = 32'h8000_2000; f_req = 1'b1;
      wait_mode = 0;
      run(6);

      // randomized traffic
      raise_pct = 30; repeat_pct = 40; wait_mode = -1;
      run(2000);
      raise_pct = 0; repeat_pct = 0;
      run(40);

      // asynchronous reset in the middle of ACCESS
      l_addr = 32'h4000_3000; l_write = 1'b1; l_wdata = 32'h1234_5678; l_req = 1'b1;
      wait_mode = 20;
      run(2);
      check_val("pre_rst_enable", 32'(bus_if.enable), 32'd1);
      #1 rst = 1'b0;
      #1;
      check_val("mid_rst_select", 32'(bus_if.select), 32'd0);
      check_val("mid_rst_enable", 32'(bus_if.enable), 32'd0);
      check_val("mid_rst_busy",   32'(busy),          32'd0);
      check_val("mid_rst_ldone",  32'(l_done),        32'd0);
      check_val("mid_rst_addr",   bus_if.addr,        32'd0);
      t_active = 1'b0; streak = 0;
      exp_addr = '0; exp_wdata = '0; exp_write = 1'b0; exp_owner = 1'b0;
      #1 rst = 1'b1;
      wait_mode = 0;
      run(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/bus_access_arbiter.md
Name: bus_access_arbiter

Overview:
Two-requester arbiter and sequencer for the core's single APB-like bus port. It shares the bus between the instruction fetch path and the load/store path. It runs the two-phase SETUP/ACCESS protocol, captures read data, and returns a one-cycle completion pulse to the owning requester. Load/store has fixed priority, with a streak limiter against fetch starvation and a ready-timeout that completes hung transfers with an error.

Parameters:
MaxLsuStreak, 4, consecutive contested LSU grants allowed before a pending fetch must win (>=1)
TimeoutCycles, 255, ACCESS-phase cycles with ready low before forced error completion; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
fetchReq  in  1  fetch request, held until fetchDone
fetchAddr  in  32  fetch address, stable while fetchReq high
fetchDone  out  1  one-cycle completion pulse to fetch
lsuReq  in  1  load/store request, held until lsuDone
lsuAddr  in  32  load/store address
lsuWrite  in  1  1 = write
lsuWdata  in  32  write data
lsuDone  out  1  one-cycle completion pulse to load/store
respRdata  out  32  captured read data, valid while either done pulse is high
respError  out  1  timeout flag, valid with done
owner  out  1  current/last grant: 0 = fetch, 1 = lsu
busy  out  1  high in SETUP, ACCESS, RESP
addr  out  32  bus address
select  out  1  bus select
enable  out  1  bus enable
write  out  1  bus write
wdata  out  32  bus write data
rdata  in  32  bus read data
ready  in  1  bus ready

Behaviour:
- Reset (rst low, async): state=IDLE; select, enable, write, fetchDone, lsuDone, respError, busy = 0; addr, wdata, respRdata = 0; owner=0; streak and timeout counters = 0. Reset mid-transfer aborts the transfer with no done pulse.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: sample requests.
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant fetch if streak==MaxLsuStreak, otherwise grant LSU.
  - On grant: register addr/write/wdata from the winner (fetch forces write=0, wdata=0), set owner, go to SETUP.
- Streak counter:
  - Increments on an LSU grant while fetchReq is also high.
  - Clears on any fetch grant, and on an LSU grant with fetchReq low.
  - Saturates at MaxLsuStreak.
- SETUP: select=1, enable=0; always advance to ACCESS next cycle.
- ACCESS: select=1, enable=1.
  - ready high: capture rdata into respRdata (writes capture 0), respError=0, go to RESP.
  - ready low: timeout counter increments. If TimeoutCycles!=0 and counter reaches TimeoutCycles, go to RESP with respRdata=0 and respError=1.
  - Counter clears on ACCESS entry.
- RESP: select=0, enable=0; assert done for the owner only, for exactly one cycle; go to IDLE.
  - Requests are ignored in RESP.
  - A requester must drop req in the done cycle or present its next transaction; a req still high in the following IDLE cycle is a new transfer.
- addr/write/wdata hold their values through SETUP and ACCESS and keep the last value in RESP and IDLE.
- select/enable are never both driven with enable=1 outside ACCESS.
- Latency: req seen in IDLE at cycle N means SETUP at N+1, ACCESS at N+2; with ready at N+2, done at N+3. Maximum throughput is one transfer per 4 cycles.
- The loser of an arbitration keeps req high and is re-arbitrated in the next IDLE.
- busy = state != IDLE.
- Both done pulses are never high together.

Test Plan:
- Single fetch: fetchReq=1, fetchAddr=0x8000_0000, ready=1 immediately, rdata=0x0000_0013 -> select at +1; enable at +2; fetchDone=1 at +3 with respRdata=0x13, respError=0; write=0 throughout.
- LSU write with wait states: lsuReq=1, lsuWrite=1, lsuAddr=0x4000_0000, lsuWdata=0xDEAD_BEEF, ready low for 3 ACCESS cycles -> addr/wdata stable for 5 cycles (SETUP + 4 ACCESS); lsuDone one cycle after ready; fetchDone stays 0.
- Starvation limit, MaxLsuStreak=4: fetchReq and lsuReq held high continuously -> grant order LSU,LSU,LSU,LSU,FETCH,LSU... ; streak clears after the fetch grant.
- Timeout, TimeoutCycles=8: ready held 0 -> exactly 8 ACCESS cycles, then RESP with done=1, respError=1, respRdata=0; next transfer with ready=1 gives respError=0.
- Async reset mid-ACCESS: assert rst=0 while enable=1 -> select, enable, busy go to 0 immediately with no done pulse; after release, a pending lsuReq is granted from IDLE.
- Back-to-back: LSU raises new req in its done cycle with new address 0x4000_0004 -> next IDLE grants it; the bus shows the new addr in SETUP 2 cycles after done.
